la_spi_sequencer: RTL and testbench

- Sequences LA-originated writes into rbzero's two SPI slaves: vectors (vec_*) and general registers (reg_*).
- Replaces LA bit-banging. The firmware hands over a left-aligned payload plus a bit count, and the block generates SPI mode-0 csb/sclk/mosi.
- One shifter is shared between the two requesters under round-robin arbitration.
- Each transfer can optionally be held until the start of vertical blanking, so view/register updates never tear a frame.
- Sits between the LA/wishbone-facing logic and top_ew_algofoogle's i_vec_* / i_reg_* inputs.

---
 rtl/la_spi_seq_pkg.sv | 39 +++
 rtl/spi_tx_shifter.sv | 78 +++++++
 rtl/la_spi_sequencer.sv | 160 ++++++++++++++++
 tb/tb_la_spi_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/la_spi_seq_pkg.sv
// rtl/la_spi_seq_pkg.sv - shared types, defaults and helpers for the LA SPI sequencer
// Contents:
//   DEF_MAX_BITS, DEF_LEN_W, DEF_HALF  default parameter values
//   state_e                            sequencer states
//   tgt_e                              SPI slave selected for a transfer
//   csb_active(), phase_timed()        state classification helpers
package la_spi_seq_pkg;

  localparam int DEF_MAX_BITS = 80;
  localparam int DEF_LEN_W    = 7;
  localparam int DEF_HALF     = 2;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_VB,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_e;

  typedef enum logic {
    TGT_VEC,
    TGT_REG
  } tgt_e;

  // States during which the selected slave's csb is driven low.
  function automatic logic csb_active(state_e s);
    return (s == SETUP) || (s == SHIFT_HI) || (s == SHIFT_LO) || (s == HOLD);
  endfunction

  // States that last exactly HALF clk cycles.
  function automatic logic phase_timed(state_e s);
    return csb_active(s) || (s == GAP);
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// rtl/spi_tx_shifter.sv - payload shift register, bit counter and SCLK half-period divider
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   load_i, data_i        latch a new left-aligned payload and clear the bit counter
//   len_i                 number of bits in the current transfer (held by the caller)
//   state_i, state_d_i    sequencer state this cycle / next cycle
//   half_end_o            current timed phase is in its last cycle
//   last_bit_o            the bit on the wire is bit len-1
//   hcnt_o                cycle index within the current timed phase
//   sclk_d_o, mosi_d_o    next-cycle SCLK/MOSI, registered per target by the caller
module spi_tx_shifter
  import la_spi_seq_pkg::*;
#(
  parameter int MAX_BITS = DEF_MAX_BITS,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int HALF     = DEF_HALF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [MAX_BITS-1:0] data_i,
  input  logic [LEN_W-1:0]    len_i,
  input  state_e              state_i,
  input  state_e              state_d_i,
  output logic                half_end_o,
  output logic                last_bit_o,
  output logic [7:0]          hcnt_o,
  output logic                sclk_d_o,
  output logic                mosi_d_o
);

  logic [MAX_BITS-1:0] sreg_q;
  logic [LEN_W-1:0]    bcnt_q;
  logic [7:0]          hcnt_q;
  logic                enter_lo;

  // The payload advances exactly when a bit's high phase ends and its low
  // phase begins, so the MSB of sreg_q is always the bit on the wire.
  assign enter_lo = (state_i == SHIFT_HI) && (state_d_i == SHIFT_LO);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q <= '0;
      bcnt_q <= '0;
      hcnt_q <= '0;
    end else begin
      if (load_i) begin
        sreg_q <= data_i;
        bcnt_q <= '0;
      end else if (enter_lo) begin
        sreg_q <= {sreg_q[MAX_BITS-2:0], 1'b0};
        bcnt_q <= bcnt_q + LEN_W'(1);
      end
      // Restart on every phase change; outside timed phases it stays at 0,
      // so waiting for vblank can never wrap it.
      if ((state_d_i == state_i) && phase_timed(state_i)) begin
        hcnt_q <= hcnt_q + 8'd1;
      end else begin
        hcnt_q <= '0;
      end
    end
  end

  assign half_end_o = (hcnt_q == 8'(HALF - 1));
  assign last_bit_o = (bcnt_q == (len_i - LEN_W'(1)));
  assign hcnt_o     = hcnt_q;

  always_comb begin
    sclk_d_o = (state_d_i == SHIFT_HI);
    mosi_d_o = 1'b0;
    if (enter_lo) begin
      mosi_d_o = sreg_q[MAX_BITS-2];
    end else if ((state_d_i == SETUP) || (state_d_i == SHIFT_HI) || (state_d_i == SHIFT_LO)) begin
      mosi_d_o = sreg_q[MAX_BITS-1];
    end
  end

endmodule

// File: rtl/la_spi_sequencer.sv
// rtl/la_spi_sequencer.sv - round-robin SPI write sequencer for rbzero vec/reg slaves
// Ports:
//   i_clk, i_reset_n                    clock, asynchronous active-low reset
//   i_vblank                            rbzero vertical blanking
//   i_vec_valid/data/len/sync, o_vec_ready   vector write request
//   i_reg_valid/data/len/sync, o_reg_ready   register write request
//   o_vec_csb/sclk/mosi                 SPI mode-0 lines to the vec slave
//   o_reg_csb/sclk/mosi                 SPI mode-0 lines to the reg slave
//   o_busy                              transfer accepted and not complete
//   o_done                              one-cycle pulse on completion
//   o_err                               one-cycle pulse on a rejected length
module la_spi_sequencer
  import la_spi_seq_pkg::*;
#(
  parameter int MAX_BITS = DEF_MAX_BITS,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int HALF     = DEF_HALF
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_vblank,
  input  logic                i_vec_valid,
  input  logic [MAX_BITS-1:0] i_vec_data,
  input  logic [LEN_W-1:0]    i_vec_len,
  input  logic                i_vec_sync,
  output logic                o_vec_ready,
  input  logic                i_reg_valid,
  input  logic [MAX_BITS-1:0] i_reg_data,
  input  logic [LEN_W-1:0]    i_reg_len,
  input  logic                i_reg_sync,
  output logic                o_reg_ready,
  output logic                o_vec_csb,
  output logic                o_vec_sclk,
  output logic                o_vec_mosi,
  output logic                o_reg_csb,
  output logic                o_reg_sclk,
  output logic                o_reg_mosi,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  state_e              state_q, state_d;
  tgt_e                tgt_q, grant_tgt;
  logic [LEN_W-1:0]    len_q, grant_len;
  logic [MAX_BITS-1:0] grant_data;
  logic                sync_q, grant_sync;
  logic                ready_q, busy_q, done_q, err_q;
  logic                vb_q, vb_prev_q, vb_rise_q;
  logic                vec_csb_q, vec_sclk_q, vec_mosi_q;
  logic                reg_csb_q, reg_sclk_q, reg_mosi_q;
  logic                grant_vec, accept, len_bad_in, len_bad_q;
  logic                half_end, last_bit, sclk_d, mosi_d;
  logic [7:0]          hcnt;

  // tgt_q doubles as the last-grant flag: on a tie the other side wins.
  assign grant_vec  = i_vec_valid && (!i_reg_valid || (tgt_q == TGT_REG));
  assign grant_tgt  = grant_vec ? TGT_VEC : TGT_REG;
  assign grant_len  = grant_vec ? i_vec_len : i_reg_len;
  assign grant_data = grant_vec ? i_vec_data : i_reg_data;
  assign grant_sync = grant_vec ? i_vec_sync : i_reg_sync;
  assign accept     = (state_q == IDLE) && ready_q && (i_vec_valid || i_reg_valid);

  assign len_bad_in = (grant_len == '0) || (grant_len > LEN_W'(MAX_BITS));
  assign len_bad_q  = (len_q == '0) || (len_q > LEN_W'(MAX_BITS));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = CHECK;
      CHECK:    state_d = len_bad_q ? IDLE : (sync_q ? WAIT_VB : SETUP);
      WAIT_VB:  if (vb_rise_q) state_d = SETUP;
      SETUP:    if (half_end) state_d = SHIFT_HI;
      SHIFT_HI: if (half_end) state_d = last_bit ? HOLD : SHIFT_LO;
      SHIFT_LO: if (half_end) state_d = SHIFT_HI;
      HOLD:     if (half_end) state_d = GAP;
      GAP:      if (half_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // All status and SPI outputs are registered from the next state, so each
  // pin changes on the same edge as the state it belongs to.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      tgt_q      <= TGT_REG;
      len_q      <= '0;
      sync_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vb_q       <= 1'b0;
      vb_prev_q  <= 1'b0;
      vb_rise_q  <= 1'b0;
      vec_csb_q  <= 1'b1;
      vec_sclk_q <= 1'b0;
      vec_mosi_q <= 1'b0;
      reg_csb_q  <= 1'b1;
      reg_sclk_q <= 1'b0;
      reg_mosi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tgt_q  <= grant_tgt;
        len_q  <= grant_len;
        sync_q <= grant_sync;
      end
      ready_q <= (state_d == IDLE);
      // A rejected request is never reported busy, even during its CHECK cycle.
      busy_q  <= (state_d != IDLE) && !(accept && len_bad_in);
      err_q   <= accept && len_bad_in;
      // Fire in the final GAP cycle: hcnt restarts at 0 on GAP entry.
      done_q  <= (state_d == GAP) &&
                 ((state_q == GAP) ? (hcnt == 8'(HALF - 2)) : (HALF == 1));
      vb_q      <= i_vblank;
      vb_prev_q <= vb_q;
      vb_rise_q <= vb_q && !vb_prev_q;
      vec_csb_q  <= !(csb_active(state_d) && (tgt_q == TGT_VEC));
      vec_sclk_q <= sclk_d && (tgt_q == TGT_VEC);
      vec_mosi_q <= mosi_d && (tgt_q == TGT_VEC);
      reg_csb_q  <= !(csb_active(state_d) && (tgt_q == TGT_REG));
      reg_sclk_q <= sclk_d && (tgt_q == TGT_REG);
      reg_mosi_q <= mosi_d && (tgt_q == TGT_REG);
    end
  end

  spi_tx_shifter #(
    .MAX_BITS (MAX_BITS),
    .LEN_W    (LEN_W),
    .HALF     (HALF)
  ) u_shifter (
    .clk_i      (i_clk),
    .rst_ni     (i_reset_n),
    .load_i     (accept),
    .data_i     (grant_data),
    .len_i      (len_q),
    .state_i    (state_q),
    .state_d_i  (state_d),
    .half_end_o (half_end),
    .last_bit_o (last_bit),
    .hcnt_o     (hcnt),
    .sclk_d_o   (sclk_d),
    .mosi_d_o   (mosi_d)
  );

  assign o_vec_ready = ready_q;
  assign o_reg_ready = ready_q;
  assign o_vec_csb   = vec_csb_q;
  assign o_vec_sclk  = vec_sclk_q;
  assign o_vec_mosi  = vec_mosi_q;
  assign o_reg_csb   = reg_csb_q;
  assign o_reg_sclk  = reg_sclk_q;
  assign o_reg_mosi  = reg_mosi_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_la_spi_sequencer.sv
// tb/tb_la_spi_sequencer.sv - directed self-checking bench for la_spi_sequencer
module tb_la_spi_sequencer;
  localparam int MAX_BITS = 80;
  localparam int LEN_W    = 7;
  localparam int HALF     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vblank = 1'b0;
  logic vec_valid = 1'b0, vec_sync = 1'b0, reg_valid = 1'b0, reg_sync = 1'b0;
  logic [MAX_BITS-1:0] vec_data = '0, reg_data = '0;
  logic [LEN_W-1:0] vec_len = '0, reg_len = '0;
  logic vec_ready, reg_ready, vec_csb, vec_sclk, vec_mosi, reg_csb, reg_sclk, reg_mosi;
  logic busy, done, err;

  int errors = 0;
  int checks = 0;

  int cap_cycles, vec_low, reg_low, vec_rises, reg_rises, vec_act, reg_act;
  int done_cnt, err_cnt, busy_cnt, vec_first_low, reg_first_low;
  logic [MAX_BITS-1:0] vec_bits, reg_bits;

  always #5 clk = ~clk;

  la_spi_sequencer #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W), .HALF(HALF)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_vblank(vblank),
    .i_vec_valid(vec_valid), .i_vec_data(vec_data), .i_vec_len(vec_len),
    .i_vec_sync(vec_sync), .o_vec_ready(vec_ready),
    .i_reg_valid(reg_valid), .i_reg_data(reg_data), .i_reg_len(reg_len),
    .i_reg_sync(reg_sync), .o_reg_ready(reg_ready),
    .o_vec_csb(vec_csb), .o_vec_sclk(vec_sclk), .o_vec_mosi(vec_mosi),
    .o_reg_csb(reg_csb), .o_reg_sclk(reg_sclk), .o_reg_mosi(reg_mosi),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  // Observes one cycle per negedge until ready returns; cap_cycles is the
  // sample index at which ready was seen (1 = first negedge after accept), -1 on timeout.
  task automatic capture(input int budget);
    logic pv, pr;
    pv = 1'b0; pr = 1'b0;
    cap_cycles = -1; vec_low = 0; reg_low = 0; vec_rises = 0; reg_rises = 0;
    vec_act = 0; reg_act = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
    vec_first_low = -1; reg_first_low = -1; vec_bits = '0; reg_bits = '0;
    for (int k = 1; k <= budget; k++) begin
      if (vec_ready) begin
        cap_cycles = k;
        break;
      end
      if (!vec_csb) begin vec_low++; if (vec_first_low < 0) vec_first_low = k; end
      if (!reg_csb) begin reg_low++; if (reg_first_low < 0) reg_first_low = k; end
      if (!vec_csb || vec_sclk || vec_mosi) vec_act++;
      if (!reg_csb || reg_sclk || reg_mosi) reg_act++;
      if (vec_sclk && !pv) begin vec_rises++; vec_bits = {vec_bits[MAX_BITS-2:0], vec_mosi}; end
      if (reg_sclk && !pr) begin reg_rises++; reg_bits = {reg_bits[MAX_BITS-2:0], reg_mosi}; end
      pv = vec_sclk; pr = reg_sclk;
      done_cnt += int'(done); err_cnt += int'(err); busy_cnt += int'(busy);
      @(negedge clk);
    end
  endtask

  // Called at a negedge with ready high; returns at the negedge after the accept edge.
  task automatic send(input bit to_vec, input logic [MAX_BITS-1:0] d,
                      input logic [LEN_W-1:0] l, input bit s);
    if (to_vec) begin vec_valid = 1'b1; vec_data = d; vec_len = l; vec_sync = s; end
    else begin reg_valid = 1'b1; reg_data = d; reg_len = l; reg_sync = s; end
    @(posedge clk);
    @(negedge clk);
    vec_valid = 1'b0; reg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({vec_csb, reg_csb, vec_sclk, reg_sclk, vec_mosi, reg_mosi} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_spi_lines: got %b want 110000",
               {vec_csb, reg_csb, vec_sclk, reg_sclk, vec_mosi, reg_mosi});
    end
    checks++;
    if ({busy, done, err, vec_ready, reg_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_status: got %b want 00000", {busy, done, err, vec_ready, reg_ready});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({vec_ready, reg_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready_first_cycle: got %b want 00", {vec_ready, reg_ready});
    end
    @(negedge clk);
    checks++;
    if ({vec_ready, reg_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready_after: got %b want 11", {vec_ready, reg_ready});
    end
  endtask

  task automatic test_back_to_back();
    int exp_grant, got_grant;
    vec_data = {8'h3C, 72'h0}; vec_len = 7'd4; vec_sync = 1'b0;
    reg_data = {8'hC3, 72'h0}; reg_len = 7'd4; reg_sync = 1'b0;
    vec_valid = 1'b1; reg_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (t == 2) begin vec_valid = 1'b0; reg_valid = 1'b0; end
      capture(200);
      exp_grant = (t % 2 == 0) ? 0 : 1;
      if (vec_low > 0 && reg_act == 0) got_grant = 0;
      else if (reg_low > 0 && vec_act == 0) got_grant = 1;
      else got_grant = 2;
      checks++;
      if (got_grant != exp_grant) begin
        errors++; $display("FAIL b2b_grant%0d: got %0d want %0d (0=vec 1=reg)", t, got_grant, exp_grant);
      end
      checks++;
      if (done_cnt != 1 || cap_cycles != 22) begin
        errors++; $display("FAIL b2b_done%0d: done=%0d ready_at=%0d want 1/22", t, done_cnt, cap_cycles);
      end
    end
  endtask

  task automatic test_basic();
    send(1'b1, {8'hA5, 72'h0}, 7'd8, 1'b0);
    capture(200);
    checks++;
    if (vec_low != 34) begin errors++; $display("FAIL basic_csb_low: got %0d want 34", vec_low); end
    checks++;
    if (vec_rises != 8) begin errors++; $display("FAIL basic_sclk_rises: got %0d want 8", vec_rises); end
    checks++;
    if (vec_bits[7:0] !== 8'hA5) begin
      errors++; $display("FAIL basic_mosi: got %h want a5", vec_bits[7:0]);
    end
    checks++;
    if (reg_act != 0) begin errors++; $display("FAIL basic_reg_idle: got %0d active cycles want 0", reg_act); end
    checks++;
    if (done_cnt != 1 || err_cnt != 0) begin
      errors++; $display("FAIL basic_done: done=%0d err=%0d want 1/0", done_cnt, err_cnt);
    end
    checks++;
    if (cap_cycles != 38) begin errors++; $display("FAIL basic_ready_latency: got %0d want 38", cap_cycles); end
  endtask

  task automatic test_sync();
    int early_low;
    vblank = 1'b1;
    repeat (4) @(negedge clk);
    send(1'b0, {16'hC3A7, 64'h0}, 7'd16, 1'b1);
    early_low = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) vblank = 1'b0;
      if (!reg_csb) early_low++;
      @(negedge clk);
    end
    checks++;
    if (early_low != 0) begin errors++; $display("FAIL sync_early_csb: got %0d low cycles want 0", early_low); end
    vblank = 1'b1;
    capture(300);
    checks++;
    if (reg_first_low != 4) begin errors++; $display("FAIL sync_csb_fall: got %0d want 4", reg_first_low); end
    checks++;
    if (reg_low != 66 || reg_rises != 16) begin
      errors++; $display("FAIL sync_frame: low=%0d rises=%0d want 66/16", reg_low, reg_rises);
    end
    checks++;
    if (reg_bits[15:0] !== 16'hC3A7) begin errors++; $display("FAIL sync_mosi: got %h want c3a7", reg_bits[15:0]); end
    checks++;
    if (done_cnt != 1 || vec_act != 0 || cap_cycles != 72) begin
      errors++; $display("FAIL sync_end: done=%0d vec_act=%0d ready_at=%0d want 1/0/72", done_cnt, vec_act, cap_cycles);
    end
  endtask

  task automatic test_len_err();
    logic [LEN_W-1:0] bad_len [2];
    bad_len[0] = 7'd0; bad_len[1] = 7'd81;
    for (int i = 0; i < 2; i++) begin
      send(i == 1, '1, bad_len[i], 1'b0);
      capture(20);
      checks++;
      if (err_cnt != 1 || done_cnt != 0) begin
        errors++; $display("FAIL err_pulse_len%0d: err=%0d done=%0d want 1/0", bad_len[i], err_cnt, done_cnt);
      end
      checks++;
      if (vec_act + reg_act != 0 || busy_cnt != 0) begin
        errors++; $display("FAIL err_quiet_len%0d: spi_act=%0d busy=%0d want 0/0", bad_len[i], vec_act + reg_act, busy_cnt);
      end
      checks++;
      if (cap_cycles != 2) begin errors++; $display("FAIL err_ready_len%0d: got %0d want 2", bad_len[i], cap_cycles); end
    end
  endtask

  task automatic test_max_len();
    logic [MAX_BITS-1:0] d;
    d = 80'hF0E1_D2C3_B4A5_9687_7869;
    send(1'b1, d, 7'd80, 1'b0);
    capture(1000);
    checks++;
    if (vec_rises != 80 || vec_low != 322) begin
      errors++; $display("FAIL max_frame: rises=%0d low=%0d want 80/322", vec_rises, vec_low);
    end
    checks++;
    if (vec_bits !== d) begin errors++; $display("FAIL max_mosi: got %h want %h", vec_bits, d); end
    checks++;
    if (vec_bits[0] !== d[0] || cap_cycles != 326) begin
      errors++; $display("FAIL max_last_bit: bit=%b ready_at=%0d want %b/326", vec_bits[0], cap_cycles, d[0]);
    end
  endtask

  task automatic test_reset_mid();
    int rises, n;
    logic pv;
    send(1'b1, {16'hBEEF, 64'h0}, 7'd16, 1'b0);
    rises = 0; n = 0; pv = 1'b0;
    while (rises < 5 && n < 200) begin
      @(posedge clk); #1;
      if (vec_sclk && !pv) rises++;
      pv = vec_sclk; n++;
    end
    checks++;
    if (rises != 5) begin errors++; $display("FAIL rst_mid_reach: got %0d rises want 5", rises); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vec_csb, vec_sclk, busy} !== 3'b100) begin
      errors++; $display("FAIL rst_mid_async: csb/sclk/busy=%b want 100", {vec_csb, vec_sclk, busy});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (vec_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready0: got %b want 0", vec_ready); end
    @(negedge clk);
    checks++;
    if (vec_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready1: got %b want 1", vec_ready); end
    send(1'b1, {8'h5A, 72'h0}, 7'd8, 1'b0);
    capture(200);
    checks++;
    if (done_cnt != 1 || vec_rises != 8 || vec_bits[7:0] !== 8'h5A || cap_cycles != 38) begin
      errors++;
      $display("FAIL rst_mid_recover: done=%0d rises=%0d bits=%h ready_at=%0d want 1/8/5a/38",
               done_cnt, vec_rises, vec_bits[7:0], cap_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_basic();
    test_sync();
    test_len_err();
    test_max_len();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
